multicycle_control_fsm: RTL and testbench
=========================================

// Module: multicycle_control_fsm
// PURPOSE
//  Control sequencer for the multi-cycle RV32I core. Latches the opcode and steps each
//  instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK with a ready handshake to
//  memory. Drives datapath enables, mux selects and ALU op-mode. Traps on illegal opcodes
//  and on memory timeouts. Sits between the instruction register and the datapath.
// PARAMETERS
//  MEM_TIMEOUT    15  max cycles waiting for mem_ready_i before fault; 0 = never time out
//  SUPPORT_AUIPC  1   1 = AUIPC (7'b0010111) legal; 0 = decoded as illegal
// PORTS
//  clk_i          in   1  clock, all state on rising edge
//  rst_i          in   1  synchronous, active-high reset
//  opcode_i       in   7  instr[6:0] from IR; sampled only in DECODE
//  mem_ready_i    in   1  memory completes current imem/dmem request this cycle
//  branch_taken_i in   1  branch condition from ALU compare, valid in EXECUTE
//  imem_req_o     out  1  instruction fetch request
//  ir_write_o     out  1  load IR and PC+4 link register
//  pc_write_o     out  1  update PC
//  pc_src_o       out  2  00=PC+4, 01=PC+imm (branch/JAL), 10=(rs1+imm)&~1 (JALR)
//  alu_a_pc_o     out  1  ALU operand A = PC (AUIPC), else rs1
//  alu_src_o      out  1  ALU operand B: 0=rs2, 1=immediate
//  alu_opmode_o   out  2  00=ADD, 01=SUB, 10=R-type, 11=I-type
//  dmem_read_o    out  1  data load request
//  dmem_write_o   out  1  data store request
//  reg_write_o    out  1  register file write enable
//  wb_sel_o       out  2  00=ALU, 01=memory data, 10=link (PC+4)
//  retire_o       out  1  one-cycle pulse when an instruction completes
//  illegal_o      out  1  sticky: trap caused by illegal opcode
//  fault_o        out  1  sticky: core halted in TRAP
//  state_o        out  3  current state encoding (debug)
// BEHAVIOUR
//  States: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5; others -> TRAP.
//  Reset: state=FETCH, op_q=0, timeout counter=0, illegal/fault cleared. Reset wins over
//   every event. While rst_i=1 all outputs are 0 and state_o=0. Reset mid-transaction drops
//   the request; no retire. alu_opmode_o and wb_sel_o default 00, other outputs default 0.
//  FETCH: imem_req_o=1. If mem_ready_i=1: ir_write_o=1, pc_write_o=1, pc_src_o=00, go to DECODE.
//  DECODE: op_q<=opcode_i. Legal opcodes are R, I, LOAD, STORE, BRANCH, JAL, JALR and LUI,
//   plus AUIPC when SUPPORT_AUIPC=1. Legal -> EXECUTE. Illegal -> TRAP with illegal_o set.
//  EXECUTE: all outputs are decoded from op_q.
//   R: opmode 10 -> WB. I: src=1, opmode 11 -> WB.
//   LUI: src=1, ADD -> WB. AUIPC: a_pc=1, src=1, ADD -> WB.
//   LOAD/STORE: src=1, ADD -> MEMORY.
//   BRANCH: opmode 01; if branch_taken_i then pc_write=1, pc_src=01; retire=1 -> FETCH.
//   JAL: pc_write=1, pc_src=01 -> WB. JALR: src=1, ADD, pc_write=1, pc_src=10 -> WB.
//  MEMORY: dmem_read_o (LOAD) or dmem_write_o (STORE) is held high until mem_ready_i.
//   STORE + ready: retire -> FETCH. LOAD + ready -> WB.
//  WRITEBACK: reg_write_o=1 for exactly 1 cycle; retire_o=1; -> FETCH.
//   wb_sel: LOAD=01, JAL/JALR=10, else 00.
//  Timeout: counter clears on entry to FETCH/MEMORY and on mem_ready_i, and increments
//   each waiting cycle. Reaching MEM_TIMEOUT with ready still low -> TRAP with fault_o=1.
//   If ready arrives in the same cycle the count expires, ready wins.
//  TRAP: fault_o=1 from the next cycle. All requests and write enables are 0. Only reset exits.
//  Latency with zero-wait memory: BRANCH 3 cycles, R/I/LUI/AUIPC/JAL/JALR/STORE 4, LOAD 5.
//   Each memory wait cycle adds 1.
// TESTING
//  addi (0010011), ready always 1 -> states 0,1,2,4,0; reg_write 1 cycle; retire every 4 cycles.
//  lw, dmem ready after 3 wait cycles -> dmem_read_o high 4 cycles, wb_sel=01, retire at cycle 8.
//  beq, taken=1 then taken=0 -> pc_write/pc_src=01 only on taken; both retire in 3 cycles.
//  jalr -> EXECUTE pc_src=10, pc_write=1; WRITEBACK wb_sel=10, reg_write=1.
//  opcode 7'b0010111 with SUPPORT_AUIPC=0 -> TRAP, illegal_o=1, fault_o=1, no reg_write.
//  fetch ready stuck low, MEM_TIMEOUT=15 -> fault_o after 15 wait cycles; rst_i -> FETCH, cleared.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// multicycle_control_fsm
//
// Control sequencer for the multi-cycle RV32I core. It steps each instruction
// through FETCH / DECODE / EXECUTE / MEMORY / WRITEBACK and uses a ready
// handshake to talk to memory. It drives the datapath enables, the mux selects
// and the ALU op-mode. Illegal opcodes and memory timeouts send it to TRAP,
// and only reset leaves TRAP.
//
// Parameters
//   MEM_TIMEOUT    : number of wait cycles allowed on a memory request before
//                    the core faults. 0 disables the timeout.
//   SUPPORT_AUIPC  : 1 makes AUIPC a legal opcode. 0 decodes it as illegal.
//
// Ports
//   clk_i          in   clock; all state changes on the rising edge
//   rst_i          in   synchronous active-high reset
//   opcode_i[6:0]  in   instr[6:0] from the IR; sampled only in DECODE
//   mem_ready_i    in   memory completes the current imem/dmem request
//   branch_taken_i in   branch compare result; valid in EXECUTE
//   imem_req_o     out  instruction fetch request
//   ir_write_o     out  load the IR and the PC+4 link register
//   pc_write_o     out  update the PC
//   pc_src_o[1:0]  out  00=PC+4, 01=PC+imm, 10=(rs1+imm)&~1
//   alu_a_pc_o     out  ALU operand A = PC (AUIPC), otherwise rs1
//   alu_src_o      out  ALU operand B: 0=rs2, 1=immediate
//   alu_opmode_o   out  00=ADD, 01=SUB, 10=R-type, 11=I-type
//   dmem_read_o    out  data load request
//   dmem_write_o   out  data store request
//   reg_write_o    out  register file write enable
//   wb_sel_o[1:0]  out  00=ALU, 01=memory data, 10=link (PC+4)
//   retire_o       out  one-cycle pulse when an instruction completes
//   illegal_o      out  sticky: the trap was caused by an illegal opcode
//   fault_o        out  sticky: the core is halted in TRAP
//   state_o[2:0]   out  current state encoding (debug)
// ---------------------------------------------------------------------------
module multicycle_control_fsm #(
    parameter int unsigned MEM_TIMEOUT   = 15,
    parameter bit          SUPPORT_AUIPC = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       imem_req_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic [1:0] pc_src_o,
    output logic       alu_a_pc_o,
    output logic       alu_src_o,
    output logic [1:0] alu_opmode_o,
    output logic       dmem_read_o,
    output logic       dmem_write_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic       retire_o,
    output logic       illegal_o,
    output logic       fault_o,
    output logic [2:0] state_o
);

    // RV32I major opcodes
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // The counter only has to reach MEM_TIMEOUT-1. When that value is
    // reached the FSM traps, so the counter never needs to go higher.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd5
    } state_t;

    state_t           state_reg,   state_next;
    logic [6:0]       op_reg,      op_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic             illegal_reg, illegal_next;
    logic             fault_reg,   fault_next;

    // Raw decoded controls. They are gated by reset at the ports.
    logic       imem_req_c;
    logic       ir_write_c;
    logic       pc_write_c;
    logic [1:0] pc_src_c;
    logic       alu_a_pc_c;
    logic       alu_src_c;
    logic [1:0] alu_opmode_c;
    logic       dmem_read_c;
    logic       dmem_write_c;
    logic       reg_write_c;
    logic [1:0] wb_sel_c;
    logic       retire_c;

    logic       opcode_legal;
    logic       timeout_hit;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg   <= ST_FETCH;
            op_reg      <= 7'd0;
            cnt_reg     <= '0;
            illegal_reg <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            op_reg      <= op_next;
            cnt_reg     <= cnt_next;
            illegal_reg <= illegal_next;
            fault_reg   <= fault_next;
        end
    end

    // ------------------------------------------------------------------
    // Opcode legality, evaluated on the live IR opcode in DECODE
    // ------------------------------------------------------------------
    always_comb begin
        opcode_legal = 1'b0;
        case (opcode_i)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI:  opcode_legal = 1'b1;
            OP_AUIPC:                 opcode_legal = SUPPORT_AUIPC;
            default:                  opcode_legal = 1'b0;
        endcase
    end

    // This is high on the last wait cycle allowed. A ready in that same
    // cycle still takes priority, because the ready branches are tested first.
    assign timeout_hit = (MEM_TIMEOUT != 0) &&
                         ((32'(cnt_reg) + 32'd1) >= MEM_TIMEOUT);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        op_next      = op_reg;
        cnt_next     = cnt_reg;
        illegal_next = illegal_reg;
        fault_next   = fault_reg;

        imem_req_c   = 1'b0;
        ir_write_c   = 1'b0;
        pc_write_c   = 1'b0;
        pc_src_c     = 2'b00;
        alu_a_pc_c   = 1'b0;
        alu_src_c    = 1'b0;
        alu_opmode_c = 2'b00;
        dmem_read_c  = 1'b0;
        dmem_write_c = 1'b0;
        reg_write_c  = 1'b0;
        wb_sel_c     = 2'b00;
        retire_c     = 1'b0;

        case (state_reg)
            ST_FETCH: begin
                imem_req_c = 1'b1;
                if (mem_ready_i) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'b00;
                    state_next = ST_DECODE;
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    fault_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_DECODE: begin
                op_next = opcode_i;
                if (opcode_legal) begin
                    state_next = ST_EXECUTE;
                end else begin
                    state_next   = ST_TRAP;
                    illegal_next = 1'b1;
                    fault_next   = 1'b1;
                end
            end

            ST_EXECUTE: begin
                case (op_reg)
                    OP_R: begin
                        alu_opmode_c = 2'b10;
                        state_next   = ST_WRITEBACK;
                    end
                    OP_I: begin
                        alu_src_c    = 1'b1;
                        alu_opmode_c = 2'b11;
                        state_next   = ST_WRITEBACK;
                    end
                    OP_LUI: begin
                        alu_src_c  = 1'b1;
                        state_next = ST_WRITEBACK;
                    end
                    OP_AUIPC: begin
                        alu_a_pc_c = 1'b1;
                        alu_src_c  = 1'b1;
                        state_next = ST_WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: begin
                        // The ALU forms the effective address rs1+imm.
                        alu_src_c  = 1'b1;
                        state_next = ST_MEMORY;
                    end
                    OP_BRANCH: begin
                        // A branch has no writeback, so it retires here.
                        alu_opmode_c = 2'b01;
                        if (branch_taken_i) begin
                            pc_write_c = 1'b1;
                            pc_src_c   = 2'b01;
                        end
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end
                    OP_JAL: begin
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'b01;
                        state_next = ST_WRITEBACK;
                    end
                    OP_JALR: begin
                        alu_src_c  = 1'b1;
                        pc_write_c = 1'b1;
                        pc_src_c   = 2'b10;
                        state_next = ST_WRITEBACK;
                    end
                    default: begin
                        // op_reg is only loaded with legal opcodes, so this
                        // branch means the state is corrupted. Halt the core.
                        state_next = ST_TRAP;
                        fault_next = 1'b1;
                    end
                endcase
            end

            ST_MEMORY: begin
                if (op_reg == OP_STORE) begin
                    dmem_write_c = 1'b1;
                end else begin
                    dmem_read_c = 1'b1;
                end
                if (mem_ready_i) begin
                    if (op_reg == OP_STORE) begin
                        retire_c   = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_WRITEBACK;
                    end
                end else if (timeout_hit) begin
                    state_next = ST_TRAP;
                    fault_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end

            ST_WRITEBACK: begin
                reg_write_c = 1'b1;
                retire_c    = 1'b1;
                case (op_reg)
                    OP_LOAD:          wb_sel_c = 2'b01;
                    OP_JAL, OP_JALR:  wb_sel_c = 2'b10;
                    default:          wb_sel_c = 2'b00;
                endcase
                state_next = ST_FETCH;
            end

            ST_TRAP: begin
                // The core stays halted here. All requests and writes stay low.
                state_next = ST_TRAP;
            end

            default: begin
                state_next = ST_TRAP;
                fault_next = 1'b1;
            end
        endcase

        // Each request that waits on memory starts its count from zero.
        // A ready from memory also resets the count.
        if (mem_ready_i ||
            ((state_next != state_reg) &&
             ((state_next == ST_FETCH) || (state_next == ST_MEMORY)))) begin
            cnt_next = '0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs are forced low while reset is asserted. This covers the first
    // reset cycle, when the state register still holds its old value, so an
    // interrupted request or retire never reaches the datapath.
    // ------------------------------------------------------------------
    assign imem_req_o   = imem_req_c   & ~rst_i;
    assign ir_write_o   = ir_write_c   & ~rst_i;
    assign pc_write_o   = pc_write_c   & ~rst_i;
    assign pc_src_o     = rst_i ? 2'b00 : pc_src_c;
    assign alu_a_pc_o   = alu_a_pc_c   & ~rst_i;
    assign alu_src_o    = alu_src_c    & ~rst_i;
    assign alu_opmode_o = rst_i ? 2'b00 : alu_opmode_c;
    assign dmem_read_o  = dmem_read_c  & ~rst_i;
    assign dmem_write_o = dmem_write_c & ~rst_i;
    assign reg_write_o  = reg_write_c  & ~rst_i;
    assign wb_sel_o     = rst_i ? 2'b00 : wb_sel_c;
    assign retire_o     = retire_c     & ~rst_i;
    assign illegal_o    = illegal_reg  & ~rst_i;
    assign fault_o      = fault_reg    & ~rst_i;
    assign state_o      = rst_i ? 3'd0 : state_reg;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// ---------------------------------------------------------------------------
// tb_multicycle_control_fsm
//
// Directed testbench for multicycle_control_fsm, with SUPPORT_AUIPC=0 and
// MEM_TIMEOUT=15. The control outputs are packed into one 15-bit vector, and
// each cycle is compared against a hand-written expectation.
//
// Vector layout, MSB to LSB:
//   imem_req, ir_write, pc_write, pc_src[1:0], alu_a_pc, alu_src,
//   alu_opmode[1:0], dmem_read, dmem_write, reg_write, wb_sel[1:0], retire
// ---------------------------------------------------------------------------
module tb_multicycle_control_fsm;

    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    logic       clk;
    logic       rst;
    logic [6:0] opcode;
    logic       mem_ready;
    logic       branch_taken;
    logic       imem_req, ir_write, pc_write, alu_a_pc, alu_src;
    logic       dmem_read, dmem_write, reg_write, retire, illegal, fault;
    logic [1:0] pc_src, alu_opmode, wb_sel;
    logic [2:0] state;
    logic [14:0] ctl;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_control_fsm #(
        .MEM_TIMEOUT   (15),
        .SUPPORT_AUIPC (1'b0)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .opcode_i       (opcode),
        .mem_ready_i    (mem_ready),
        .branch_taken_i (branch_taken),
        .imem_req_o     (imem_req),
        .ir_write_o     (ir_write),
        .pc_write_o     (pc_write),
        .pc_src_o       (pc_src),
        .alu_a_pc_o     (alu_a_pc),
        .alu_src_o      (alu_src),
        .alu_opmode_o   (alu_opmode),
        .dmem_read_o    (dmem_read),
        .dmem_write_o   (dmem_write),
        .reg_write_o    (reg_write),
        .wb_sel_o       (wb_sel),
        .retire_o       (retire),
        .illegal_o      (illegal),
        .fault_o        (fault),
        .state_o        (state)
    );

    assign ctl = {imem_req, ir_write, pc_write, pc_src, alu_a_pc, alu_src,
                  alu_opmode, dmem_read, dmem_write, reg_write, wb_sel, retire};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [14:0] mk(
        input logic imem, input logic irw, input logic pcw, input logic [1:0] pcs,
        input logic apc, input logic src, input logic [1:0] opm,
        input logic dr, input logic dw, input logic rw, input logic [1:0] wbs,
        input logic ret);
        return {imem, irw, pcw, pcs, apc, src, opm, dr, dw, rw, wbs, ret};
    endfunction

    task automatic chk_cyc(input string tag, input logic [2:0] st,
                           input logic [14:0] cv);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_ctl"},   32'(ctl),   32'(cv));
    endtask

    // Move to 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply this cycle's inputs, then let the combinational outputs settle.
    task automatic drive(input logic rdy, input logic tk, input logic [6:0] opc);
        mem_ready    = rdy;
        branch_taken = tk;
        opcode       = opc;
        #1;
    endtask

    // Watchdog in case the bench sequencing itself stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [14:0] f_rdy, f_wait, idle;
        idle   = '0;
        f_rdy  = mk(1,1,1,2'b00,0,0,2'b00,0,0,0,2'b00,0);
        f_wait = mk(1,0,0,2'b00,0,0,2'b00,0,0,0,2'b00,0);

        rst = 1'b1;
        drive(1'b1, 1'b0, 7'd0);
        tick();
        tick();

        // Reset state: every output is low while reset is held.
        drive(1'b1, 1'b0, 7'd0);
        chk_cyc("reset", 3'd0, idle);
        check("reset_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        // addi twice with ready always high: states 0,1,2,4 and one retire
        // every 4 cycles.
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, OP_I); chk_cyc("addi_fetch", 3'd0, f_rdy); tick();
            drive(1'b1, 1'b0, OP_I); chk_cyc("addi_decode", 3'd1, idle); tick();
            drive(1'b1, 1'b0, OP_I);
            chk_cyc("addi_exec", 3'd2, mk(0,0,0,2'b00,0,1,2'b11,0,0,0,2'b00,0)); tick();
            drive(1'b1, 1'b0, OP_I);
            chk_cyc("addi_wb", 3'd4, mk(0,0,0,2'b00,0,0,2'b00,0,0,1,2'b00,1)); tick();
            $display("[TB] addi #%0d retired", k);
        end

        // lw: dmem ready arrives after 3 wait cycles, and the instruction
        // retires in cycle 8.
        drive(1'b1, 1'b0, OP_LOAD); chk_cyc("lw_fetch", 3'd0, f_rdy); tick();
        drive(1'b0, 1'b0, OP_LOAD); chk_cyc("lw_decode", 3'd1, idle); tick();
        drive(1'b0, 1'b0, OP_LOAD);
        chk_cyc("lw_exec", 3'd2, mk(0,0,0,2'b00,0,1,2'b00,0,0,0,2'b00,0)); tick();
        for (int i = 0; i < 4; i++) begin
            drive(i == 3, 1'b0, OP_LOAD);
            chk_cyc("lw_mem", 3'd3, mk(0,0,0,2'b00,0,0,2'b00,1,0,0,2'b00,0)); tick();
        end
        drive(1'b1, 1'b0, OP_LOAD);
        chk_cyc("lw_wb", 3'd4, mk(0,0,0,2'b00,0,0,2'b00,0,0,1,2'b01,1)); tick();
        $display("[TB] lw retired");

        // sw with zero-wait memory retires directly from MEMORY.
        drive(1'b1, 1'b0, OP_STORE); chk_cyc("sw_fetch", 3'd0, f_rdy); tick();
        drive(1'b1, 1'b0, OP_STORE); chk_cyc("sw_decode", 3'd1, idle); tick();
        drive(1'b1, 1'b0, OP_STORE);
        chk_cyc("sw_exec", 3'd2, mk(0,0,0,2'b00,0,1,2'b00,0,0,0,2'b00,0)); tick();
        drive(1'b1, 1'b0, OP_STORE);
        chk_cyc("sw_mem", 3'd3, mk(0,0,0,2'b00,0,0,2'b00,0,1,0,2'b00,1)); tick();
        $display("[TB] sw retired");

        // beq taken, then beq not taken. Each retires in 3 cycles.
        for (int k = 0; k < 2; k++) begin
            logic tk;
            tk = (k == 0);
            drive(1'b1, tk, OP_BRANCH); chk_cyc("beq_fetch", 3'd0, f_rdy); tick();
            drive(1'b1, tk, OP_BRANCH); chk_cyc("beq_decode", 3'd1, idle); tick();
            drive(1'b1, tk, OP_BRANCH);
            if (tk)
                chk_cyc("beq_taken", 3'd2, mk(0,0,1,2'b01,0,0,2'b01,0,0,0,2'b00,1));
            else
                chk_cyc("beq_nottaken", 3'd2, mk(0,0,0,2'b00,0,0,2'b01,0,0,0,2'b00,1));
            tick();
            $display("[TB] beq taken=%0b retired", tk);
        end

        // jalr: pc_src=10 in EXECUTE, then the link value is written back.
        drive(1'b1, 1'b0, OP_JALR); chk_cyc("jalr_fetch", 3'd0, f_rdy); tick();
        drive(1'b1, 1'b0, OP_JALR); chk_cyc("jalr_decode", 3'd1, idle); tick();
        drive(1'b1, 1'b0, OP_JALR);
        chk_cyc("jalr_exec", 3'd2, mk(0,0,1,2'b10,0,1,2'b00,0,0,0,2'b00,0)); tick();
        drive(1'b1, 1'b0, OP_JALR);
        chk_cyc("jalr_wb", 3'd4, mk(0,0,0,2'b00,0,0,2'b00,0,0,1,2'b10,1)); tick();
        $display("[TB] jalr retired");

        // lw whose dmem ready arrives on the 15th wait cycle. Ready takes
        // priority over the timeout, so there is no fault.
        drive(1'b1, 1'b0, OP_LOAD); chk_cyc("lwto_fetch", 3'd0, f_rdy); tick();
        drive(1'b0, 1'b0, OP_LOAD); tick();
        drive(1'b0, 1'b0, OP_LOAD); tick();
        for (int i = 0; i < 15; i++) begin
            drive(i == 14, 1'b0, OP_LOAD);
            chk_cyc("lwto_mem", 3'd3, mk(0,0,0,2'b00,0,0,2'b00,1,0,0,2'b00,0)); tick();
        end
        drive(1'b1, 1'b0, OP_LOAD);
        chk_cyc("lwto_wb", 3'd4, mk(0,0,0,2'b00,0,0,2'b00,0,0,1,2'b01,1));
        check("lwto_fault", 32'(fault), 32'd0);
        tick();
        $display("[TB] lw with late ready retired");

        // AUIPC is illegal when SUPPORT_AUIPC=0, so the core traps and
        // never writes a register.
        drive(1'b1, 1'b0, OP_AUIPC); chk_cyc("auipc_fetch", 3'd0, f_rdy); tick();
        drive(1'b1, 1'b0, OP_AUIPC); chk_cyc("auipc_decode", 3'd1, idle); tick();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, OP_AUIPC);
            chk_cyc("auipc_trap", 3'd5, idle);
            check("auipc_illegal", 32'(illegal), 32'd1);
            check("auipc_fault", 32'(fault), 32'd1);
            tick();
        end
        $display("[TB] auipc trapped");

        // Reset leaves TRAP and clears the sticky flags.
        rst = 1'b1;
        drive(1'b0, 1'b0, 7'd0);
        chk_cyc("trap_rst", 3'd0, idle);
        tick();
        rst = 1'b0;

        // Fetch ready stuck low: the core faults after 15 wait cycles.
        for (int i = 0; i < 15; i++) begin
            drive(1'b0, 1'b0, 7'd0);
            chk_cyc("to_fetch", 3'd0, f_wait);
            check("to_fault_low", 32'(fault), 32'd0);
            check("to_illegal_low", 32'(illegal), 32'd0);
            tick();
        end
        drive(1'b0, 1'b0, 7'd0);
        chk_cyc("to_trap", 3'd5, idle);
        check("to_fault", 32'(fault), 32'd1);
        check("to_illegal", 32'(illegal), 32'd0);
        tick();
        $display("[TB] fetch timeout trapped");

        rst = 1'b1;
        drive(1'b0, 1'b0, 7'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 7'd0);
        chk_cyc("to_after_rst", 3'd0, f_wait);
        check("to_after_rst_fault", 32'(fault), 32'd0);

        // Reset during a pending load drops the request and does not retire.
        drive(1'b1, 1'b0, OP_LOAD); tick();
        drive(1'b0, 1'b0, OP_LOAD); tick();
        drive(1'b0, 1'b0, OP_LOAD); tick();
        drive(1'b1, 1'b0, OP_LOAD);
        chk_cyc("mid_mem", 3'd3, mk(0,0,0,2'b00,0,0,2'b00,1,0,0,2'b00,0));
        rst = 1'b1;
        #1;
        chk_cyc("mid_rst", 3'd0, idle);
        tick();
        rst = 1'b0;
        drive(1'b1, 1'b0, OP_I);
        chk_cyc("mid_after", 3'd0, f_rdy);
        $display("[TB] reset mid-transaction dropped request");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
